// File: rtl/td4_prog_rom.sv
// Writable 16x8 program memory for the TD4 core with a byte-wide load port.
// Latency: DATA_ROM is combinational from ADDR_ROM; a loaded byte is visible after its accepting edge.
// Backpressure: LOAD_READY is decoded from state only, high in LOAD (and CHECK), one byte per cycle.
//
// Ports:
//   CLK, CLR_N          clock and asynchronous active-low reset
//   ADDR_ROM, DATA_ROM  CPU fetch address and returned instruction byte
//   LOAD_START          restarts a program load from address 0 (any state)
//   LOAD_DATA/VALID/READY  valid/ready byte load port
//   CPU_CLR_N           registered active-low reset to the CPU, high only in RUN
//   LOADING, ERROR      status: loading/checking, checksum failure
//
// Optional feature: define TD4_PROG_ROM_CHECKSUM_EN to require a trailing
// checksum byte (CHECK state) and flag a mismatch in the ERR state.
module td4_prog_rom #(
    parameter int DEPTH = 16
) (
    input  logic       CLK,
    input  logic       CLR_N,
    input  logic [3:0] ADDR_ROM,
    output logic [7:0] DATA_ROM,
    input  logic       LOAD_START,
    input  logic [7:0] LOAD_DATA,
    input  logic       LOAD_VALID,
    output logic       LOAD_READY,
    output logic       CPU_CLR_N,
    output logic       LOADING,
    output logic       ERROR
);

    typedef enum logic [2:0] {
        S_HALT  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2
`ifdef TD4_PROG_ROM_CHECKSUM_EN
        ,
        S_CHECK = 3'd3,
        S_ERR   = 3'd4
`endif
    } state_t;

    localparam logic [3:0] LAST_ADDR = 4'(DEPTH - 1);

    state_t      state;
    state_t      next_state;
    logic [7:0]  mem [DEPTH];
    logic [3:0]  wr_ptr;
    logic        load_ready;
    logic        loading;
    logic        error;
    logic        write_en;
    logic        cpu_clr_n;

    // A LOAD_START in the same cycle as a beat wins: the beat is dropped.
    assign write_en = (state == S_LOAD) && LOAD_VALID && !LOAD_START;

    // Read path: purely combinational, valid in every state.
    assign DATA_ROM = mem[ADDR_ROM];

`ifdef TD4_PROG_ROM_CHECKSUM_EN
    logic [7:0] sum;
    logic [7:0] sum_total;

    // Checksum byte C passes when S + C wraps to zero.
    assign sum_total = sum + LOAD_DATA;

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            sum <= 8'h00;
        end else if (LOAD_START) begin
            sum <= 8'h00;
        end else if (write_en) begin
            sum <= sum_total;
        end
    end
`endif

    // State register
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state <= S_HALT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        if (LOAD_START) begin
            next_state = S_LOAD;
        end else begin
            case (state)
                S_HALT: next_state = S_HALT;
                S_LOAD: begin
                    if (write_en && (wr_ptr == LAST_ADDR)) begin
`ifdef TD4_PROG_ROM_CHECKSUM_EN
                        next_state = S_CHECK;
`else
                        next_state = S_RUN;
`endif
                    end
                end
                S_RUN:  next_state = S_RUN;
`ifdef TD4_PROG_ROM_CHECKSUM_EN
                S_CHECK: begin
                    if (LOAD_VALID) begin
                        next_state = (sum_total == 8'h00) ? S_RUN : S_ERR;
                    end
                end
                S_ERR:  next_state = S_ERR;
`endif
                default: next_state = S_HALT;
            endcase
        end
    end

    // Output decode: from the state register only, no path from LOAD_VALID.
    always_comb begin
        load_ready = 1'b0;
        loading    = 1'b0;
        error      = 1'b0;
        case (state)
            S_LOAD: begin
                load_ready = 1'b1;
                loading    = 1'b1;
            end
`ifdef TD4_PROG_ROM_CHECKSUM_EN
            S_CHECK: begin
                load_ready = 1'b1;
                loading    = 1'b1;
            end
            S_ERR: error = 1'b1;
`endif
            default: ;
        endcase
    end

    assign LOAD_READY = load_ready;
    assign LOADING    = loading;
`ifdef TD4_PROG_ROM_CHECKSUM_EN
    assign ERROR      = error;
`else
    assign ERROR      = 1'b0;
`endif

    // CPU reset follows the next state so it releases on the edge that
    // completes the load, and the CPU fetches address 0 on the next cycle.
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            cpu_clr_n <= 1'b0;
        end else begin
            cpu_clr_n <= (next_state == S_RUN);
        end
    end

    assign CPU_CLR_N = cpu_clr_n;

    // Write pointer wraps to 0 naturally after the last byte.
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            wr_ptr <= 4'd0;
        end else if (LOAD_START) begin
            wr_ptr <= 4'd0;
        end else if (write_en) begin
            wr_ptr <= wr_ptr + 4'd1;
        end
    end

    // Program storage; earlier bytes survive a restart until overwritten.
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (write_en) begin
            mem[wr_ptr] <= LOAD_DATA;
        end
    end

endmodule
